// File: rtl/arq_pkg.sv
// Shared types and constants for the stop-and-wait ARQ transmit controller.
package arq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  localparam logic [1:0] ACK = 2'b01;
  localparam logic [1:0] NAK = 2'b10;

  // A zero retry limit still needs a one-bit counter.
  function automatic int retry_w(input int max_retry);
    if (max_retry < 1) begin
      return 1;
    end else begin
      return $clog2(max_retry + 1);
    end
  endfunction

endpackage

// File: rtl/arq_timer.sv
// Saturating response timer; expire flags the last WAIT cycle (count == TIMEOUT-1).
module arq_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_r;

  // Count while enabled, stop at LAST so the value never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != LAST)) begin
      count_r <= count_r + TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == LAST);

endmodule

// File: rtl/arq_tx_ctrl.sv
// Stop-and-wait ARQ transmitter: frames one host word with a sequence bit,
// resends on NAK or timeout up to MAX_RETRY times, then reports done or fail.
module arq_tx_ctrl
  import arq_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3,
  localparam int RW       = retry_w(MAX_RETRY)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              busy_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        ack_nak,
  output logic              ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_seq,
  output logic              done,
  output logic              fail,
  output logic [RW-1:0]     retry_cnt
);

  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  state_t              state_r, next_s;
  logic [DATA_W-1:0]   buffer_r, buffer_nxt_s;
  logic [DATA_W-1:0]   tx_data_r, tx_data_nxt_s;
  logic [RW-1:0]       retry_cnt_r, retry_nxt_s;
  logic                seq_r, seq_nxt_s;
  logic                ready_r, ready_nxt_s;
  logic                tx_valid_r, tx_valid_nxt_s;
  logic                done_r, done_nxt_s;
  logic                fail_r, fail_nxt_s;
  logic                expire_s, accept_s, resend_s, ack_s, nak_s;

  arq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_r == S_SEND),
    .en      (state_r == S_WAIT),
    .expire  (expire_s)
  );

  assign ack_s = (state_r == S_WAIT) && (ack_nak == ACK);
  assign nak_s = (state_r == S_WAIT) && (ack_nak == NAK);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic; ACK beats a coincident timeout, NAK+timeout is one retry.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (busy_n) next_s = S_READY;
        else        next_s = S_IDLE;
      end
      S_READY: begin
        if (!busy_n)  next_s = S_IDLE;
        else if (we)  next_s = S_SEND;
        else          next_s = S_READY;
      end
      S_SEND: next_s = S_WAIT;
      S_WAIT: begin
        if (ack_s) begin
          next_s = busy_n ? S_READY : S_IDLE;
        end else if (nak_s || expire_s) begin
          next_s = (retry_cnt_r == MAX_R) ? S_FAIL : S_SEND;
        end else begin
          next_s = S_WAIT;
        end
      end
      S_FAIL: begin
        if (busy_n) next_s = S_READY;
        else        next_s = S_IDLE;
      end
      default: next_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    accept_s       = (state_r == S_READY) && (next_s == S_SEND);
    resend_s       = (state_r == S_WAIT)  && (next_s == S_SEND);
    ready_nxt_s    = (next_s == S_READY);
    tx_valid_nxt_s = (next_s == S_SEND);
    done_nxt_s     = ack_s;
    fail_nxt_s     = (next_s == S_FAIL);

    if (accept_s) begin
      buffer_nxt_s  = wdata;
      tx_data_nxt_s = wdata;
      retry_nxt_s   = '0;
    end else if (resend_s) begin
      buffer_nxt_s  = buffer_r;
      tx_data_nxt_s = buffer_r;
      retry_nxt_s   = retry_cnt_r + RW'(1);
    end else if (state_r == S_FAIL) begin
      buffer_nxt_s  = '0;
      tx_data_nxt_s = tx_data_r;
      retry_nxt_s   = retry_cnt_r;
    end else begin
      buffer_nxt_s  = buffer_r;
      tx_data_nxt_s = tx_data_r;
      retry_nxt_s   = retry_cnt_r;
    end

    // The receiver expects a fresh sequence bit after success and after giving up.
    if (ack_s || (state_r == S_FAIL)) begin
      seq_nxt_s = ~seq_r;
    end else begin
      seq_nxt_s = seq_r;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer_r    <= '0;
      tx_data_r   <= '0;
      retry_cnt_r <= '0;
      seq_r       <= 1'b0;
      ready_r     <= 1'b0;
      tx_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      buffer_r    <= buffer_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      retry_cnt_r <= retry_nxt_s;
      seq_r       <= seq_nxt_s;
      ready_r     <= ready_nxt_s;
      tx_valid_r  <= tx_valid_nxt_s;
      done_r      <= done_nxt_s;
      fail_r      <= fail_nxt_s;
    end
  end

  assign ready     = ready_r;
  assign tx_valid  = tx_valid_r;
  assign tx_data   = tx_data_r;
  assign tx_seq    = seq_r;
  assign done      = done_r;
  assign fail      = fail_r;
  assign retry_cnt = retry_cnt_r;

endmodule

// File: tb/tb_arq_tx_ctrl.sv
// Scoreboard bench for arq_tx_ctrl: expected frames/done/fail are queued by the
// stimulus and checked by a negedge monitor as the DUT emits them.
module tb_arq_tx_ctrl;
  import arq_pkg::*;

  localparam int DW = 8;
  localparam int TO = 16;
  localparam int MR = 3;
  localparam int RW = retry_w(MR);
  localparam int K_TX = 0, K_DONE = 1, K_FAIL = 2;

  logic          clk = 1'b0;
  logic          reset_n, busy_n, we;
  logic [DW-1:0] wdata;
  logic [1:0]    ack_nak;
  logic          ready, tx_valid, tx_seq, done, fail;
  logic [DW-1:0] tx_data;
  logic [RW-1:0] retry_cnt;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    logic        seq;
    int          retry;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_tx  = 0;

  arq_tx_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset_n(reset_n), .busy_n(busy_n), .we(we), .wdata(wdata),
    .ack_nak(ack_nak), .ready(ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_seq(tx_seq), .done(done), .fail(fail), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data, input logic seq,
                      input int retry, input int gap);
    exp_t e;
    e.kind = kind; e.data = data; e.seq = seq; e.retry = retry; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event kind=%0d actual=present required=none (t=%0t)", kind, $time);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == K_TX) begin
        chk("tx_data", tx_data, e.data);
        chk("tx_seq", tx_seq, e.seq);
        if (e.gap != 0) chk("tx_gap", cyc - last_tx, e.gap);
        last_tx = cyc;
      end else begin
        chk("evt_retry_cnt", retry_cnt, e.retry);
        if (e.gap != 0) chk("evt_gap", cyc - last_tx, e.gap);
      end
    end
  endtask

  // Monitor: compare every emitted pulse against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (tx_valid === 1'b1) take(K_TX);
      if (done === 1'b1)     take(K_DONE);
      if (fail === 1'b1)     take(K_FAIL);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tx();
    int k = 0;
    while (tx_valid !== 1'b1 && k < 100) begin
      step(1);
      k++;
    end
    if (tx_valid !== 1'b1) chk("wait_tx_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [7:0] d);
    we = 1'b1; wdata = d;
    step(1);
    we = 1'b0;
  endtask

  task automatic respond(input logic [1:0] r);
    step(1);
    ack_nak = r;
    step(1);
    ack_nak = 2'b00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_fail"}, fail, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_tx_seq"}, tx_seq, 1'b0);
    chk({tag, "_retry_cnt"}, retry_cnt, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int k;
    reset_n = 1'b0; busy_n = 1'b0; we = 1'b0; wdata = 8'h00; ack_nak = 2'b00;
    step(2);
    chk_all_zero("reset");
    reset_n = 1'b1;
    step(1);
    chk("idle_ready", ready, 1'b0);
    busy_n = 1'b1;
    step(1);
    chk("ready_after_busy_n", ready, 1'b1);

    // Word A5 acknowledged on first try.
    push(K_TX, 8'hA5, 1'b0, 0, 0);
    push(K_DONE, 8'h00, 1'b0, 0, 0);
    send_word(8'hA5);
    chk("ready_drop", ready, 1'b0);
    wait_tx();
    respond(ACK);
    chk("t1_ready", ready, 1'b1);
    chk("t1_seq", tx_seq, 1'b1);

    // Word 3C: NAK, NAK, ACK.
    push(K_TX, 8'h3C, 1'b1, 0, 0);
    push(K_TX, 8'h3C, 1'b1, 0, 0);
    push(K_TX, 8'h3C, 1'b1, 0, 0);
    push(K_DONE, 8'h00, 1'b0, 2, 0);
    send_word(8'h3C);
    wait_tx(); respond(NAK);
    wait_tx(); respond(NAK);
    wait_tx(); respond(ACK);
    chk("t2_retry_cnt", retry_cnt, 2'd2);
    chk("t2_seq", tx_seq, 1'b0);

    // Word 5A: silence until retries exhausted.
    push(K_TX, 8'h5A, 1'b0, 0, 0);
    push(K_TX, 8'h5A, 1'b0, 0, 17);
    push(K_TX, 8'h5A, 1'b0, 0, 17);
    push(K_TX, 8'h5A, 1'b0, 0, 17);
    push(K_FAIL, 8'h00, 1'b0, 3, 17);
    send_word(8'h5A);
    k = 0;
    while (fail !== 1'b1 && k < 200) begin
      step(1);
      k++;
    end
    if (fail !== 1'b1) chk("wait_fail_timeout", 32'd0, 32'd1);
    step(1);
    chk("t3_ready", ready, 1'b1);
    chk("t3_seq", tx_seq, 1'b1);
    chk("t3_retry_cnt", retry_cnt, 2'd3);

    // Word C3: ACK on the exact expiry cycle.
    push(K_TX, 8'hC3, 1'b1, 0, 0);
    push(K_DONE, 8'h00, 1'b0, 0, 17);
    send_word(8'hC3);
    step(16);
    ack_nak = ACK;
    step(1);
    ack_nak = 2'b00;
    chk("t4_retry_cnt", retry_cnt, 2'd0);
    chk("t4_seq", tx_seq, 1'b0);
    step(20);

    // busy_n drop beats a simultaneous write.
    busy_n = 1'b0; we = 1'b1; wdata = 8'hFF;
    step(1);
    we = 1'b0;
    chk("t5_ready_low", ready, 1'b0);
    step(3);
    chk("t5_still_idle", ready, 1'b0);
    busy_n = 1'b1;
    step(1);
    chk("t5_ready_back", ready, 1'b1);

    // Reset in the middle of WAIT after one NAK.
    push(K_TX, 8'h77, 1'b0, 0, 0);
    push(K_TX, 8'h77, 1'b0, 0, 0);
    send_word(8'h77);
    wait_tx(); respond(NAK);
    wait_tx(); step(1);
    chk("t6_pre_retry", retry_cnt, 2'd1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("t6_ready", ready, 1'b1);
    chk("t6_seq", tx_seq, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_fail", fail, 1'b0);

    step(5);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
